// File: rtl/seg_scan_driver.sv
// Digit scan controller for the clock display: steps a one-hot digit select and
// feeds the 7-segment decoder either BCD digits or a slowly scrolling message index.
module seg_scan_driver #(
    parameter int SCAN_DIV = 50000,
    parameter int CHAR_DIV = 250,
    parameter int MSG_LEN  = 7
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] D0,
    input  logic [3:0] D1,
    input  logic [3:0] D2,
    input  logic [3:0] D3,
    input  logic       TOP_CURRENT_STATE,
    input  logic [1:0] DIS_CURRENT_STATE,
    output logic [3:0] SA,
    output logic [3:0] COUNT,
    output logic       MSG_WRAP
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (CHAR_DIV > 1) ? $clog2(CHAR_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(CHAR_DIV - 1);
    localparam logic [3:0]    CHAR_LAST  = 4'(MSG_LEN - 1);

    logic [SW-1:0] scan_cnt;
    logic [1:0]    ptr;
    logic [FW-1:0] frame_cnt;
    logic [3:0]    char_idx;
    logic [1:0]    mode_prev;

    logic          msg_lo, msg_hi, msg, msg_prev, entry;
    logic [1:0]    mode;
    logic          scan_tc, frame_tick, frame_tc;
    logic [1:0]    ptr_nxt;
    logic [FW-1:0] frame_nxt;
    logic [3:0]    idx_nxt;
    logic          wrap_nxt;
    logic [3:0]    d_sel, count_nxt;
    logic          use_idx, load_count;

    // Digit pair 0/1 wins when both pairs request message mode.
    assign msg_lo   = TOP_CURRENT_STATE & DIS_CURRENT_STATE[0];
    assign msg_hi   = TOP_CURRENT_STATE & DIS_CURRENT_STATE[1] & ~DIS_CURRENT_STATE[0];
    assign msg      = msg_lo | msg_hi;
    assign mode     = {msg_hi, msg_lo};
    assign msg_prev = |mode_prev;
    assign entry    = msg & ~msg_prev;

    assign scan_tc    = (scan_cnt == SCAN_LAST);
    assign ptr_nxt    = ptr + {1'b0, scan_tc};
    assign frame_tick = scan_tc && (ptr == 2'd3);
    assign frame_tc   = frame_tick && (frame_cnt == FRAME_LAST);

    always_comb begin
        frame_nxt = frame_cnt;
        idx_nxt   = char_idx;
        wrap_nxt  = 1'b0;
        if (!msg || entry) begin
            frame_nxt = '0;
            idx_nxt   = '0;
        end else if (frame_tc) begin
            frame_nxt = '0;
            if (char_idx == CHAR_LAST) begin
                idx_nxt  = '0;
                wrap_nxt = 1'b1;
            end else begin
                idx_nxt = char_idx + 4'd1;
            end
        end else if (frame_tick) begin
            frame_nxt = frame_cnt + 1'b1;
        end
    end

    always_comb begin
        d_sel = D0;
        case (ptr_nxt)
            2'd0: d_sel = D0;
            2'd1: d_sel = D1;
            2'd2: d_sel = D2;
            2'd3: d_sel = D3;
            default: d_sel = D0;
        endcase
    end

    // COUNT reloads at each digit boundary, and also mid-hold when the mode changes.
    assign use_idx    = (msg_lo && !ptr_nxt[1]) || (msg_hi && ptr_nxt[1]);
    assign count_nxt  = use_idx ? idx_nxt : d_sel;
    assign load_count = scan_tc || (mode != mode_prev);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            scan_cnt  <= '0;
            ptr       <= '0;
            frame_cnt <= '0;
            char_idx  <= '0;
            mode_prev <= '0;
            SA        <= 4'b0001;
            COUNT     <= '0;
            MSG_WRAP  <= 1'b0;
        end else begin
            scan_cnt  <= scan_tc ? '0 : scan_cnt + 1'b1;
            ptr       <= ptr_nxt;
            frame_cnt <= frame_nxt;
            char_idx  <= idx_nxt;
            mode_prev <= mode;
            MSG_WRAP  <= wrap_nxt;
            SA        <= 4'b0001 << ptr_nxt;
            if (load_count) COUNT <= count_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=4, CHAR_DIV=2, MSG_LEN=7;
// expected values are computed from the edge count since reset release.
module tb_seg_scan_driver;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] D0 = '0, D1 = '0, D2 = '0, D3 = '0;
    logic       TOP_CURRENT_STATE = 1'b0;
    logic [1:0] DIS_CURRENT_STATE = 2'b00;
    logic [3:0] SA, COUNT;
    logic       MSG_WRAP;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n        = 0;
    logic [3:0] dv [4];

    seg_scan_driver #(.SCAN_DIV(4), .CHAR_DIV(2), .MSG_LEN(7)) dut (
        .CLK(CLK), .RST(RST), .D0(D0), .D1(D1), .D2(D2), .D3(D3),
        .TOP_CURRENT_STATE(TOP_CURRENT_STATE), .DIS_CURRENT_STATE(DIS_CURRENT_STATE),
        .SA(SA), .COUNT(COUNT), .MSG_WRAP(MSG_WRAP)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, n, obs, exp);
        end
    endtask

    task automatic set_d(input logic [3:0] d0, d1, d2, d3);
        D0 = d0; D1 = d1; D2 = d2; D3 = d3;
        dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
    endtask

    function automatic int dig(input int e);
        return (e / 4) % 4;
    endfunction

    // Assert reset between edges, check the asynchronous values, release on a falling edge.
    task automatic reset_dut();
        @(negedge CLK);
        RST = 1'b0;
        #2;
        check("rst_sa", SA, 4'b0001);
        check("rst_count", COUNT, 4'd0);
        check("rst_wrap", MSG_WRAP, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        n = 0;
    endtask

    // Advance one edge and check SA, MSG_WRAP and optionally COUNT.
    task automatic step(input bit chk_cnt, input logic [3:0] exp_cnt, input bit exp_wrap);
        logic [3:0] exp_sa;
        @(posedge CLK);
        #1;
        n++;
        exp_sa = 4'b0001 << dig(n);
        check("sa", SA, exp_sa);
        check("msg_wrap", MSG_WRAP, exp_wrap);
        if (chk_cnt) check("count", COUNT, exp_cnt);
    endtask

    initial begin
        logic [3:0] e;
        int         p;

        // Normal scan, D3..D0 = 1,2,3,4
        set_d(4'd4, 4'd3, 4'd2, 4'd1);
        reset_dut();
        for (int i = 1; i <= 40; i++) begin
            p = dig(i);
            step(i >= 4, dv[p], 1'b0);
        end

        // Asynchronous reset in the middle of digit 2
        reset_dut();
        for (int i = 1; i <= 9; i++) step(1'b0, 4'd0, 1'b0);
        #2;
        RST = 1'b0;
        #1;
        check("async_sa", SA, 4'b0001);
        check("async_count", COUNT, 4'd0);
        @(negedge CLK);
        RST = 1'b1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            p = dig(i);
            step(i >= 4, dv[p], 1'b0);
        end

        // Message on digits 0/1, entry coincident with a frame boundary at edge 16
        reset_dut();
        for (int i = 1; i <= 15; i++) step(1'b0, 4'd0, 1'b0);
        @(negedge CLK);
        TOP_CURRENT_STATE = 1'b1;
        DIS_CURRENT_STATE = 2'b01;
        for (int i = 16; i <= 260; i++) begin
            p = dig(i);
            e = 4'(((i - 16) / 32) % 7);
            step(1'b1, (p < 2) ? e : dv[p], i == 240);
        end

        // DIS=11 then 10 then TOP dropped
        @(negedge CLK);
        DIS_CURRENT_STATE = 2'b11;
        RST = 1'b0;
        #2;
        @(negedge CLK);
        RST = 1'b1;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            p = dig(i);
            step(1'b1, (p < 2) ? 4'd0 : dv[p], 1'b0);
        end
        @(negedge CLK);
        DIS_CURRENT_STATE = 2'b10;
        for (int i = 11; i <= 26; i++) begin
            p = dig(i);
            step(1'b1, (p >= 2) ? 4'd0 : dv[p], 1'b0);
        end
        @(negedge CLK);
        TOP_CURRENT_STATE = 1'b0;
        for (int i = 27; i <= 40; i++) begin
            p = dig(i);
            step(1'b1, dv[p], 1'b0);
        end

        // Re-entry while index=4 restarts the index and frame counter
        set_d(4'd8, 4'd7, 4'd6, 4'd5);
        TOP_CURRENT_STATE = 1'b1;
        DIS_CURRENT_STATE = 2'b01;
        reset_dut();
        for (int i = 1; i <= 149; i++) begin
            p = dig(i);
            e = 4'((i / 32) % 7);
            step(1'b1, (p < 2) ? e : dv[p], 1'b0);
        end
        @(negedge CLK);
        TOP_CURRENT_STATE = 1'b0;
        step(1'b1, dv[1], 1'b0);
        @(negedge CLK);
        TOP_CURRENT_STATE = 1'b1;
        for (int i = 151; i <= 200; i++) begin
            p = dig(i);
            e = (i >= 176) ? 4'd1 : 4'd0;
            step(1'b1, (p < 2) ? e : dv[p], 1'b0);
        end

        // Non-BCD values pass through in normal mode
        TOP_CURRENT_STATE = 1'b0;
        DIS_CURRENT_STATE = 2'b00;
        set_d(4'hF, 4'hC, 4'hB, 4'hA);
        reset_dut();
        for (int i = 1; i <= 31; i++) begin
            p = dig(i);
            step(i >= 4, dv[p], 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
